p1_maxpool_engine: RTL

- Pooling-1 compute stage. Reads the 24x24 conv-1 feature map from a dual-port memory and performs 2x2 stride-2 signed max pooling.
- Emits the 12x12 result as 72 output pairs:
  - lane 0 carries pooled rows 0-5;
  - lane 1 carries pooled rows 6-11.
- Sits directly upstream of the pooling-1 output write counter. Each out_valid pulse corresponds to one write at bank addresses k and k+72.

---
 rtl/p1_pool_pkg.sv | 43 ++++
 rtl/p1_window_max.sv | 37 +++
 rtl/p1_maxpool_engine.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/p1_pool_pkg.sv
// Shared sizes, FSM state type and tap address helper for the pooling-1 engine.
//   DATA_W      signed feature width
//   IN_DIM      conv-1 map side
//   OUT_DIM     pooled map side
//   ADDR_W      conv-1 memory address width
//   PAIRS       output pairs per run (lane 0: pooled rows 0-5, lane 1: rows 6-11)
//   BANK_OFFSET address distance between lane 0 and lane 1 windows
package p1_pool_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned IN_DIM      = 24;
  localparam int unsigned OUT_DIM     = 12;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned HALF_ROWS   = OUT_DIM / 2;
  localparam int unsigned PAIRS       = HALF_ROWS * OUT_DIM;
  localparam int unsigned BANK_OFFSET = HALF_ROWS * 2 * IN_DIM;

  localparam int unsigned ROW_W = $clog2(HALF_ROWS);
  localparam int unsigned COL_W = $clog2(OUT_DIM);
  localparam int unsigned TAP_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAST,
    EMIT,
    DONE
  } pool_state_t;

  // Lane-0 address of one 2x2 tap: (2r+dy)*IN_DIM + 2c+dx, tap = {dy,dx}.
  function automatic logic [ADDR_W-1:0] tap_addr(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col,
    input logic [TAP_W-1:0] tap
  );
    logic [ADDR_W-1:0] in_row;
    logic [ADDR_W-1:0] in_col;
    in_row = ADDR_W'({row, tap[1]});
    in_col = ADDR_W'({col, tap[0]});
    return (in_row * ADDR_W'(IN_DIM)) + in_col;
  endfunction

endpackage

// File: rtl/p1_window_max.sv
// One signed running-max lane over a 2x2 pooling window.
//   clk, reset  clock, asynchronous active-high reset
//   clear       zero the accumulator
//   load        take rd_data as the first window value
//   update      keep the larger of rd_data and the accumulator
//   rd_data     word returned by the conv-1 memory
//   max_c       combinational max(rd_data, acc), used to capture the final word
module p1_window_max
  import p1_pool_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              update,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] max_c
);

  logic [DATA_W-1:0] acc;

  assign max_c = ($signed(rd_data) > $signed(acc)) ? rd_data : acc;

  // Loading the first word (not a constant) keeps all-negative windows exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (load) begin
      acc <= rd_data;
    end else if (update) begin
      acc <= max_c;
    end
  end

endmodule

// File: rtl/p1_maxpool_engine.sv
// Pooling-1 engine: 2x2 stride-2 signed max pooling of the 24x24 conv-1 map,
// emitted as 72 pairs (lane 0 = pooled rows 0-5, lane 1 = pooled rows 6-11).
//   clk, reset           clock, asynchronous active-high reset
//   enable               start request, sampled in IDLE only
//   rd_addr0/rd_addr1    conv-1 memory read addresses (port A / port B)
//   rd_data0/rd_data1    read data, one cycle after the address
//   out_data0/out_data1  pooled values for pair k and k+72
//   out_valid            one-cycle pulse per pair
//   done                 all pairs emitted; held until reset
// Build option: define P1_RELU_EN to clamp negative pooled results to zero.
module p1_maxpool_engine
  import p1_pool_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  input  logic [DATA_W-1:0] rd_data0,
  input  logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic              out_valid,
  output logic              done
);

  pool_state_t       state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr0_d;
  logic [DATA_W-1:0] out0_d, out1_d;
  logic              valid_d;
  logic              done_d;

  logic              acc_clear_c;
  logic              acc_load_c;
  logic              acc_update_c;
  logic [DATA_W-1:0] max0_c, max1_c;

  logic              col_wrap_c;
  logic              last_pair_c;
  logic [ROW_W-1:0]  row_next_c;
  logic [COL_W-1:0]  col_next_c;

  function automatic logic [DATA_W-1:0] emit_value(input logic [DATA_W-1:0] m);
`ifdef P1_RELU_EN
    return m[DATA_W-1] ? '0 : m;
`else
    return m;
`endif
  endfunction

  // Raster advance of the pooled (row, col) position.
  assign col_wrap_c  = (col_q == COL_W'(OUT_DIM - 1));
  assign last_pair_c = col_wrap_c && (row_q == ROW_W'(HALF_ROWS - 1));
  assign col_next_c  = col_wrap_c ? '0 : col_q + COL_W'(1);
  assign row_next_c  = col_wrap_c ? row_q + ROW_W'(1) : row_q;

  p1_window_max u_lane0 (
    .clk     (clk),
    .reset   (reset),
    .clear   (acc_clear_c),
    .load    (acc_load_c),
    .update  (acc_update_c),
    .rd_data (rd_data0),
    .max_c   (max0_c)
  );

  p1_window_max u_lane1 (
    .clk     (clk),
    .reset   (reset),
    .clear   (acc_clear_c),
    .load    (acc_load_c),
    .update  (acc_update_c),
    .rd_data (rd_data1),
    .max_c   (max1_c)
  );

  // Next state, counters and registered-output values.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    row_d        = row_q;
    col_d        = col_q;
    addr0_d      = rd_addr0;
    out0_d       = out_data0;
    out1_d       = out_data1;
    valid_d      = 1'b0;
    done_d       = done;
    acc_clear_c  = 1'b0;
    acc_load_c   = 1'b0;
    acc_update_c = 1'b0;

    case (state_q)
      IDLE: begin
        acc_clear_c = 1'b1;
        if (enable) begin
          state_d = READ;
          tap_d   = '0;
          addr0_d = tap_addr(row_q, col_q, TAP_W'(0));
        end
      end

      READ: begin
        // Data trails the address by one cycle: tap 1 cycle sees word 0.
        if (tap_q == TAP_W'(1)) begin
          acc_load_c = 1'b1;
        end else if (tap_q != TAP_W'(0)) begin
          acc_update_c = 1'b1;
        end
        if (tap_q == TAP_W'(3)) begin
          state_d = LAST;
        end else begin
          tap_d   = tap_q + TAP_W'(1);
          addr0_d = tap_addr(row_q, col_q, tap_q + TAP_W'(1));
        end
      end

      LAST: begin
        // Fourth word arrives now; capture the final max straight to the output.
        acc_update_c = 1'b1;
        state_d      = EMIT;
        valid_d      = 1'b1;
        out0_d       = emit_value(max0_c);
        out1_d       = emit_value(max1_c);
      end

      EMIT: begin
        if (last_pair_c) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = READ;
          tap_d   = '0;
          row_d   = row_next_c;
          col_d   = col_next_c;
          addr0_d = tap_addr(row_next_c, col_next_c, TAP_W'(0));
        end
      end

      DONE: begin
        done_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      rd_addr0  <= '0;
      rd_addr1  <= '0;
      out_data0 <= '0;
      out_data1 <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rd_addr0  <= addr0_d;
      rd_addr1  <= addr0_d + ADDR_W'(BANK_OFFSET);
      out_data0 <= out0_d;
      out_data1 <= out1_d;
      out_valid <= valid_d;
      done      <= done_d;
    end
  end

endmodule
